// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, size encodings and alignment check for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Only the two low address bits decide alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-side signals of the arbiter
interface mem_arbiter_if #(
    parameter int BITSIZE = 32
);
    logic               instr_req_i;
    logic [31:0]        instr_addr_i;
    logic               instr_ack_o;
    logic [BITSIZE-1:0] instr_rdata_o;
    logic               instr_err_o;

    logic               data_req_i;
    logic [31:0]        data_addr_i;
    logic [BITSIZE-1:0] data_wdata_i;
    logic               data_we_i;
    logic [1:0]         data_size_i;
    logic               data_ack_o;
    logic [BITSIZE-1:0] data_rdata_o;
    logic               data_err_o;

    logic [31:0]        mem_addr_o;
    logic [BITSIZE-1:0] mem_data_o;
    logic [BITSIZE-1:0] mem_data_i;
    logic               mem_write_o;
    logic [1:0]         mem_write_size_o;
    logic               mem_valid_o;
    logic               mem_valid_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_wdata_i, data_we_i, data_size_i,
        input  mem_data_i, mem_valid_i,
        output instr_ack_o, instr_rdata_o, instr_err_o,
        output data_ack_o, data_rdata_o, data_err_o,
        output mem_addr_o, mem_data_o, mem_write_o, mem_write_size_o, mem_valid_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_wdata_i, data_we_i, data_size_i,
        output mem_data_i, mem_valid_i,
        input  instr_ack_o, instr_rdata_o, instr_err_o,
        input  data_ack_o, data_rdata_o, data_err_o,
        input  mem_addr_o, mem_data_o, mem_write_o, mem_write_size_o, mem_valid_o
    );

endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker; bit 0 = fetch, bit 1 = load/store
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    port_t rr_ptr_q, rr_ptr_d;

    // The pointer only moves on contention, so a lone requester never steals the next turn.
    always_comb begin
        grant    = 2'b00;
        rr_ptr_d = rr_ptr_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                grant = (rr_ptr_q == PORT_DATA) ? 2'b10 : 2'b01;
                if (advance) begin
                    rr_ptr_d = (rr_ptr_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            rr_ptr_q <= PORT_DATA;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one combinational memory between fetch and load/store ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITSIZE        = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         resetn_i,
    mem_arbiter_if.slave bus,
    output logic         busy_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state_q, state_d;
    port_t              port_q, port_d;
    logic [31:0]        addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BITSIZE-1:0] rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [1:0]         grant;

    mem_arb_rr u_rr (
        .clk      (clk),
        .resetn_i (resetn_i),
        .req      ({bus.data_req_i, bus.instr_req_i}),
        .advance  (state_q == IDLE),
        .grant    (grant)
    );

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    port_d  = grant[1] ? PORT_DATA : PORT_INSTR;
                    addr_d  = grant[1] ? bus.data_addr_i : bus.instr_addr_i;
                    wdata_d = grant[1] ? bus.data_wdata_i : '0;
                    we_d    = grant[1] & bus.data_we_i;
                    size_d  = grant[1] ? bus.data_size_i : SIZE_WORD;
                    cnt_d   = '0;
                    rdata_d = '0;
                    // Bad requests are answered straight away without touching memory.
                    if ((size_d == 2'b11) || is_misaligned(addr_d[1:0], size_d)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_valid_i) begin
                    rdata_d = we_q ? '0 : bus.mem_data_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            port_q  <= PORT_INSTR;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy_o               = (state_q != IDLE);
    assign bus.mem_valid_o      = (state_q == ACCESS);
    assign bus.mem_write_o      = (state_q == ACCESS) & we_q;
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_data_o       = wdata_q;
    assign bus.mem_write_size_o = size_q;

    assign bus.instr_ack_o   = (state_q == RESP) && (port_q == PORT_INSTR);
    assign bus.instr_rdata_o = bus.instr_ack_o ? rdata_q : '0;
    assign bus.instr_err_o   = bus.instr_ack_o & err_q;
    assign bus.data_ack_o    = (state_q == RESP) && (port_q == PORT_DATA);
    assign bus.data_rdata_o  = bus.data_ack_o ? rdata_q : '0;
    assign bus.data_err_o    = bus.data_ack_o & err_q;

endmodule
